// File: rtl/seg_display_pkg.sv
// Shared types and constants for the count display slice: converter state
// encoding, active-low segment patterns and a nibble-to-segment decoder.
package seg_display_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } conv_state_t;

   localparam int DIGIT_IDX_W = 2;

   // Active-low patterns, bit order {g,f,e,d,c,b,a}
   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h10;
   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [3:0] AN_OFF    = 4'hF;

   // Nibbles above 9 cannot come out of the converter; show blank if one does
   function automatic logic [6:0] seg_decode(input logic [3:0] nib);
      logic [6:0] pat;
      case (nib)
         4'd0:    pat = SEG_0;
         4'd1:    pat = SEG_1;
         4'd2:    pat = SEG_2;
         4'd3:    pat = SEG_3;
         4'd4:    pat = SEG_4;
         4'd5:    pat = SEG_5;
         4'd6:    pat = SEG_6;
         4'd7:    pat = SEG_7;
         4'd8:    pat = SEG_8;
         4'd9:    pat = SEG_9;
         default: pat = SEG_BLANK;
      endcase
      return pat;
   endfunction

endpackage

// File: rtl/bin2bcd_8.sv
// Sequential double-dabble converter, 8-bit binary to 3 BCD digits.
// start is honoured only in IDLE; 8 shift iterations follow, then DONE
// publishes the result to bcd in a single edge so it is never partial.
module bin2bcd_8
   import seg_display_pkg::*;
(
   input  logic        clk_100MHz,
   input  logic        rst_n,
   input  logic        start,
   input  logic [7:0]  bin,
   output logic        busy,
   output logic        done,
   output logic [11:0] bcd
);

   conv_state_t state_reg, state_next;
   logic [7:0]  bin_reg, bin_next;
   logic [11:0] scratch_reg, scratch_next;
   logic [2:0]  iter_reg, iter_next;
   logic [11:0] bcd_reg, bcd_next;
   logic [11:0] adj;

   // Add-3 correction on every scratch nibble that is 5 or more
   for (genvar gi = 0; gi < 3; gi++) begin : g_adj
      assign adj[4*gi +: 4] = (scratch_reg[4*gi +: 4] >= 4'd5) ?
                              scratch_reg[4*gi +: 4] + 4'd3 :
                              scratch_reg[4*gi +: 4];
   end

   // Converter state and datapath registers
   always_ff @(posedge clk_100MHz or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= IDLE;
         bin_reg     <= '0;
         scratch_reg <= '0;
         iter_reg    <= '0;
         bcd_reg     <= '0;
      end else begin
         state_reg   <= state_next;
         bin_reg     <= bin_next;
         scratch_reg <= scratch_next;
         iter_reg    <= iter_next;
         bcd_reg     <= bcd_next;
      end
   end

   // Next-state and datapath update for the three-state converter
   always_comb begin
      state_next   = state_reg;
      bin_next     = bin_reg;
      scratch_next = scratch_reg;
      iter_next    = iter_reg;
      bcd_next     = bcd_reg;
      case (state_reg)
         IDLE: begin
            if (start) begin
               bin_next     = bin;
               scratch_next = '0;
               iter_next    = '0;
               state_next   = SHIFT;
            end
         end
         SHIFT: begin
            {scratch_next, bin_next} = {adj, bin_reg} << 1;
            iter_next = iter_reg + 3'd1;
            if (iter_reg == 3'd7) begin
               state_next = DONE;
            end
         end
         DONE: begin
            bcd_next   = scratch_reg;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign busy = (state_reg != IDLE);
   assign done = (state_reg == DONE);
   assign bcd  = bcd_reg;

endmodule

// File: rtl/count_seg_display.sv
// Count display: binary count -> BCD -> 4-digit multiplexed common-anode
// 7-segment display. Digits 0..2 show ones/tens/hundreds; digit 3 is blank.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zeros on hundreds/tens.
module count_seg_display
   import seg_display_pkg::*;
#(
   parameter int SCAN_DIV     = 100000,
   parameter int BLANK_CYCLES = 100
)
(
   input  logic       clk_100MHz,
   input  logic       rst_n,
   input  logic [7:0] value,
   output logic [6:0] seg,
   output logic       dp,
   output logic [3:0] an,
   output logic       conv_busy
);

   localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(SCAN_DIV - 1);
   localparam logic [PRE_W-1:0] BLANK_LIM = PRE_W'(BLANK_CYCLES);

   logic        start;
   logic        busy;
   logic        done;
   logic [11:0] bcd;
   logic [7:0]  last_value_reg;
   logic [7:0]  snapshot_reg;
   logic        dirty_reg;

   logic [PRE_W-1:0]       pre_reg;
   logic [DIGIT_IDX_W-1:0] idx_reg;
   logic [3:0]             an_sel;
   logic [6:0]             digit_seg [4];
   logic [6:0]             seg_reg;
   logic [3:0]             an_reg;
   logic                   dp_reg;

   // Start a conversion whenever idle and the shown value is stale
   assign start = !busy && (dirty_reg || (value != last_value_reg));

   bin2bcd_8 u_conv (
      .clk_100MHz (clk_100MHz),
      .rst_n      (rst_n),
      .start      (start),
      .bin        (value),
      .busy       (busy),
      .done       (done),
      .bcd        (bcd)
   );

   // Track which value the display holds; dirty forces one post-reset pass
   always_ff @(posedge clk_100MHz or negedge rst_n) begin
      if (!rst_n) begin
         snapshot_reg   <= '0;
         last_value_reg <= '0;
         dirty_reg      <= 1'b1;
      end else begin
         if (start) begin
            snapshot_reg <= value;
         end
         if (done) begin
            last_value_reg <= snapshot_reg;
            dirty_reg      <= 1'b0;
         end
      end
   end

   // Scan prescaler and digit index, advancing one digit per slot
   always_ff @(posedge clk_100MHz or negedge rst_n) begin
      if (!rst_n) begin
         pre_reg <= '0;
         idx_reg <= '0;
      end else if (pre_reg == PRE_LAST) begin
         pre_reg <= '0;
         idx_reg <= idx_reg + 1'b1;
      end else begin
         pre_reg <= pre_reg + 1'b1;
      end
   end

   // One-hot active-low anode for the current index
   for (genvar gi = 0; gi < 4; gi++) begin : g_an
      assign an_sel[gi] = (idx_reg != DIGIT_IDX_W'(gi));
   end

   assign digit_seg[0] = seg_decode(bcd[3:0]);
`ifdef LEADING_ZERO_BLANK_EN
   assign digit_seg[1] = ((bcd[11:8] == 4'd0) && (bcd[7:4] == 4'd0)) ?
                         SEG_BLANK : seg_decode(bcd[7:4]);
   assign digit_seg[2] = (bcd[11:8] == 4'd0) ? SEG_BLANK : seg_decode(bcd[11:8]);
`else
   assign digit_seg[1] = seg_decode(bcd[7:4]);
   assign digit_seg[2] = seg_decode(bcd[11:8]);
`endif
   assign digit_seg[3] = SEG_BLANK;

   // Registered pin drivers; all anodes off during the anti-ghost window
   always_ff @(posedge clk_100MHz or negedge rst_n) begin
      if (!rst_n) begin
         seg_reg <= SEG_BLANK;
         an_reg  <= AN_OFF;
         dp_reg  <= 1'b1;
      end else begin
         dp_reg <= 1'b1;
         if (pre_reg < BLANK_LIM) begin
            seg_reg <= SEG_BLANK;
            an_reg  <= AN_OFF;
         end else begin
            seg_reg <= digit_seg[idx_reg];
            an_reg  <= an_sel;
         end
      end
   end

   assign seg       = seg_reg;
   assign an        = an_reg;
   assign dp        = dp_reg;
   assign conv_busy = busy;

endmodule

// File: tb/tb_count_seg_display.sv
// Directed bench for count_seg_display with a shortened scan (SCAN_DIV=10,
// BLANK_CYCLES=2). Expected values are hand-computed constants.
module tb_count_seg_display;

   logic        clk_100MHz = 1'b0;
   logic        rst_n      = 1'b0;
   logic [7:0]  value      = 8'd0;
   logic [6:0]  seg;
   logic        dp;
   logic [3:0]  an;
   logic        conv_busy;
   logic [11:0] bcd_obs;

   int n_cmp = 0;
   int n_bad = 0;

`ifdef LEADING_ZERO_BLANK_EN
   localparam bit LZB = 1'b1;
`else
   localparam bit LZB = 1'b0;
`endif
   localparam logic [6:0] ZH = LZB ? 7'h7F : 7'h40;  // leading zero look

   always #5 clk_100MHz = ~clk_100MHz;

   count_seg_display #(.SCAN_DIV(10), .BLANK_CYCLES(2)) dut (
      .clk_100MHz (clk_100MHz),
      .rst_n      (rst_n),
      .value      (value),
      .seg        (seg),
      .dp         (dp),
      .an         (an),
      .conv_busy  (conv_busy)
   );

   assign bcd_obs = dut.u_conv.bcd;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_100MHz);
      #1;
   endtask

   // Release reset, then check two scan frames, busy window and digits
   task automatic run_after_release(input string tag, input logic [11:0] exp_bcd,
                                    input logic [6:0] eh, input logic [6:0] et,
                                    input logic [6:0] eo);
      logic [3:0] one;
      logic [3:0] exp_an;
      logic [6:0] digs [4];
      int busy_cnt;
      int busy_last;
      int pre;
      int idx;
      one = 4'b0001;
      busy_cnt = 0;
      busy_last = 0;
      for (int d = 0; d < 4; d++) digs[d] = 7'h2A;
      @(negedge clk_100MHz);
      rst_n = 1'b1;
      for (int n = 1; n <= 80; n++) begin
         step();
         pre = (n - 1) % 10;
         idx = ((n - 1) / 10) % 4;
         exp_an = (pre < 2) ? 4'hF : ~(one << idx);
         check_val({tag, "_an"}, an, exp_an);
         if (pre < 2) check_val({tag, "_blank_seg"}, seg, 7'h7F);
         else digs[idx] = seg;
         if (conv_busy) begin
            busy_cnt++;
            busy_last = n;
         end
      end
      check_val({tag, "_busy_cycles"}, busy_cnt, 9);
      check_val({tag, "_busy_last"}, busy_last, 9);
      check_val({tag, "_bcd"}, bcd_obs, exp_bcd);
      check_val({tag, "_hund"}, digs[2], eh);
      check_val({tag, "_tens"}, digs[1], et);
      check_val({tag, "_ones"}, digs[0], eo);
      check_val({tag, "_dig3"}, digs[3], 7'h7F);
      check_val({tag, "_dp"}, dp, 1'b1);
      $display("release %s: bcd=%h busy_cycles=%0d", tag, bcd_obs, busy_cnt);
   endtask

   // Apply a new value and time the busy window and result
   task automatic conv_measure(input string tag, input logic [7:0] v, input logic [11:0] exp_bcd);
      int cnt;
      int first;
      cnt = 0;
      first = 0;
      value = v;
      for (int i = 1; i <= 30; i++) begin
         step();
         if (conv_busy) begin
            if (cnt == 0) first = i;
            cnt++;
         end else if (cnt > 0) begin
            break;
         end
      end
      check_val({tag, "_busy_first"}, first, 1);
      check_val({tag, "_busy_cycles"}, cnt, 9);
      check_val({tag, "_bcd"}, bcd_obs, exp_bcd);
      $display("convert %s: value=%0d bcd=%h busy_cycles=%0d", tag, v, bcd_obs, cnt);
   endtask

   // Watch one full frame and check what each anode slot shows
   task automatic frame_check(input string tag, input logic [6:0] eh,
                              input logic [6:0] et, input logic [6:0] eo);
      logic [6:0] digs [4];
      for (int d = 0; d < 4; d++) digs[d] = 7'h2A;
      for (int i = 0; i < 41; i++) begin
         step();
         case (an)
            4'hE: digs[0] = seg;
            4'hD: digs[1] = seg;
            4'hB: digs[2] = seg;
            4'h7: digs[3] = seg;
            default: ;
         endcase
      end
      check_val({tag, "_hund"}, digs[2], eh);
      check_val({tag, "_tens"}, digs[1], et);
      check_val({tag, "_ones"}, digs[0], eo);
      check_val({tag, "_dig3"}, digs[3], 7'h7F);
      $display("frame %s: h=%h t=%h o=%h d3=%h", tag, digs[2], digs[1], digs[0], digs[3]);
   endtask

   initial begin
      int t1, t2, nchg;
      logic [11:0] v1, v2, prev;
      logic [3:0] prev_an;
      bit synced;

      // Reset state
      #12;
      check_val("rst_seg", seg, 7'h7F);
      check_val("rst_an", an, 4'hF);
      check_val("rst_dp", dp, 1'b1);
      check_val("rst_busy", conv_busy, 1'b0);
      $display("reset: seg=%h an=%h dp=%b busy=%b", seg, an, dp, conv_busy);
      run_after_release("init0", 12'h000, ZH, ZH, 7'h40);

      // Full-scale value
      conv_measure("v255", 8'd255, 12'h255);
      frame_check("v255", 7'h24, 7'h12, 7'h12);

      // Single-digit value, leading zeros
      conv_measure("v7", 8'd7, 12'h007);
      frame_check("v7", ZH, ZH, 7'h78);

      // Value changes mid-conversion: old snapshot finishes, then restart
      value = 8'd100;
      prev = bcd_obs;
      nchg = 0; t1 = 0; t2 = 0; v1 = '0; v2 = '0;
      for (int i = 1; i <= 25; i++) begin
         step();
         if (i == 2) value = 8'd200;
         if (bcd_obs != prev) begin
            nchg++;
            if (nchg == 1) begin t1 = i; v1 = bcd_obs; end
            if (nchg == 2) begin t2 = i; v2 = bcd_obs; end
            prev = bcd_obs;
         end
      end
      check_val("mid_changes", nchg, 2);
      check_val("mid_t1", t1, 10);
      check_val("mid_v1", v1, 12'h100);
      check_val("mid_t2", t2, 20);
      check_val("mid_v2", v2, 12'h200);
      $display("midchange: changes=%0d t1=%0d v1=%h t2=%0d v2=%h", nchg, t1, v1, t2, v2);
      frame_check("v200", 7'h24, 7'h40, 7'h40);

      // Async reset in the middle of SHIFT and in a lit slot
      synced = 1'b0;
      prev_an = an;
      for (int i = 0; i < 50; i++) begin
         step();
         if (prev_an == 4'hF && an != 4'hF) begin
            synced = 1'b1;
            break;
         end
         prev_an = an;
      end
      check_val("slot_sync", synced, 1'b1);
      value = 8'd55;
      step(); step(); step();
      check_val("pre_rst_busy", conv_busy, 1'b1);
      check_val("pre_rst_an_lit", (an != 4'hF), 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      check_val("async_seg", seg, 7'h7F);
      check_val("async_an", an, 4'hF);
      check_val("async_busy", conv_busy, 1'b0);
      check_val("async_dp", dp, 1'b1);
      check_val("async_bcd", bcd_obs, 12'h000);
      $display("async reset: seg=%h an=%h busy=%b", seg, an, conv_busy);
      run_after_release("rst55", 12'h055, ZH, 7'h12, 7'h12);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
